// File: rtl/edit_field_ctrl_pkg.sv
// Shared definitions for the edit-field controller: FSM states, mode codes,
// per-mode BCD field limits and field packing offsets.
package edit_field_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StEdit   = 2'd1,
        StCommit = 2'd2
    } state_e;

    localparam logic [1:0] ModeNone  = 2'd0;
    localparam logic [1:0] ModeHour  = 2'd1;
    localparam logic [1:0] ModeDate  = 2'd2;
    localparam logic [1:0] ModeTimer = 2'd3;

    // Field packing inside the 24-bit word
    localparam int unsigned FieldW    = 8;
    localparam int unsigned Field0Lsb = 0;
    localparam int unsigned Field1Lsb = 8;
    localparam int unsigned Field2Lsb = 16;

    // BCD limits
    localparam logic [7:0] BcdZero   = 8'h00;
    localparam logic [7:0] HourMax   = 8'h23;
    localparam logic [7:0] MinSecMax = 8'h59;
    localparam logic [7:0] DayMin    = 8'h01;
    localparam logic [7:0] DayMax    = 8'h31;
    localparam logic [7:0] MonthMin  = 8'h01;
    localparam logic [7:0] MonthMax  = 8'h12;
    localparam logic [7:0] YearMax   = 8'h99;

    // Lowest legal value of field idx in the given mode
    function automatic logic [7:0] field_min(input logic [1:0] mode, input logic [1:0] idx);
        logic [7:0] v;
        v = BcdZero;
        if (mode == ModeDate) begin
            if (idx == 2'd2) begin
                v = DayMin;
            end else if (idx == 2'd1) begin
                v = MonthMin;
            end
        end
        return v;
    endfunction

    // Highest legal value of field idx in the given mode (timer shares hour limits)
    function automatic logic [7:0] field_max(input logic [1:0] mode, input logic [1:0] idx);
        logic [7:0] v;
        if (mode == ModeDate) begin
            if (idx == 2'd2) begin
                v = DayMax;
            end else if (idx == 2'd1) begin
                v = MonthMax;
            end else begin
                v = YearMax;
            end
        end else begin
            if (idx == 2'd2) begin
                v = HourMax;
            end else begin
                v = MinSecMax;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/edit_field_ctrl_bcd_step.sv
// Combinational wrap-around increment/decrement of one 2-digit BCD value.
// A value that is not legal BCD or lies outside [min, max] snaps to min.
module edit_field_ctrl_bcd_step (
    input  logic [7:0] i_val,
    input  logic [7:0] i_min,
    input  logic [7:0] i_max,
    input  logic       i_dir_up,
    output logic [7:0] o_val
);

    logic w_legal;

    // Range compares are valid as plain binary once both digits are <= 9
    assign w_legal = (i_val[7:4] <= 4'd9) && (i_val[3:0] <= 4'd9) &&
                     (i_val >= i_min) && (i_val <= i_max);

    // Next value: snap, wrap, or step with decimal carry/borrow
    always_comb begin
        o_val = i_min;
        if (!w_legal) begin
            o_val = i_min;
        end else if (i_dir_up) begin
            if (i_val == i_max) begin
                o_val = i_min;
            end else if (i_val[3:0] == 4'd9) begin
                o_val = {i_val[7:4] + 4'd1, 4'd0};
            end else begin
                o_val = {i_val[7:4], i_val[3:0] + 4'd1};
            end
        end else begin
            if (i_val == i_min) begin
                o_val = i_max;
            end else if (i_val[3:0] == 4'd0) begin
                o_val = {i_val[7:4] - 4'd1, 4'd9};
            end else begin
                o_val = {i_val[7:4], i_val[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/edit_field_ctrl.sv
// User-edit controller for hour/date/timer fields with RTC commit handshake.
// Optional build macro: EDIT_AUTOREPEAT_EN enables hold-to-repeat on Up/Down.
module edit_field_ctrl
    import edit_field_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT   = 255,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_up,
    input  logic        i_down,
    input  logic        i_left,
    input  logic        i_rigth,
    input  logic        i_ok,
    input  logic        i_f0,
    input  logic        i_f1,
    input  logic        i_f2,
    input  logic [23:0] i_cur_data,
    input  logic        i_write_ack,
    output logic [23:0] o_edit_data,
    output logic [1:0]  o_cursor,
    output logic [1:0]  o_edit_mode,
    output logic        o_editing,
    output logic        o_write_req,
    output logic        o_err
);

    localparam logic [7:0] AckLast = 8'(ACK_TIMEOUT - 1);

    state_e      r_state;
    logic [23:0] r_edit_data;
    logic [1:0]  r_cursor;
    logic [1:0]  r_edit_mode;
    logic        r_editing;
    logic        r_write_req;
    logic        r_err;
    logic [7:0]  r_ack_cnt;
    logic [4:0]  r_btn_prev;

    logic [4:0]  w_btn;
    logic [4:0]  w_press;
    logic [1:0]  w_mode;
    logic        w_rep_fire;
    logic        w_up_step;
    logic        w_down_step;
    logic [7:0]  w_sel_val;
    logic [7:0]  w_step_val;
    logic [7:0]  w_min;
    logic [7:0]  w_max;
    logic [23:0] w_new_data;

    // Bit order sets press priority: ok, up, down, left, rigth
    assign w_btn   = {i_ok, i_up, i_down, i_left, i_rigth};
    assign w_press = w_btn & ~r_btn_prev;

    // Switch decode, F0 wins over F1 over F2
    always_comb begin
        w_mode = ModeNone;
        if (i_f0) begin
            w_mode = ModeHour;
        end else if (i_f1) begin
            w_mode = ModeDate;
        end else if (i_f2) begin
            w_mode = ModeTimer;
        end
    end

`ifdef EDIT_AUTOREPEAT_EN
    logic [31:0] r_rep_cnt;
    logic        r_repeating;

    assign w_rep_fire = (r_state == StEdit) && (i_up || i_down) &&
                        (r_repeating ? (r_rep_cnt == 32'(REPEAT_CYCLES - 1))
                                     : (r_rep_cnt == 32'(HOLD_CYCLES - 1)));

    // Hold timer: restarts on every fresh Up/Down press, clears on release or leaving EDIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
        end else if ((r_state != StEdit) || !(i_up || i_down) || w_press[3] || w_press[2]) begin
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_repeating <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + 32'd1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_rep_fire   = 1'b0;
    assign w_unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

    assign w_up_step   = w_press[3] | (w_rep_fire & i_up);
    assign w_down_step = w_press[2] | (w_rep_fire & ~i_up & i_down);

    assign w_min = field_min(r_edit_mode, r_cursor);
    assign w_max = field_max(r_edit_mode, r_cursor);

    // Select the field under the cursor and splice the stepped value back
    always_comb begin
        w_new_data = r_edit_data;
        case (r_cursor)
            2'd0: begin
                w_sel_val                          = r_edit_data[Field0Lsb +: FieldW];
                w_new_data[Field0Lsb +: FieldW]    = w_step_val;
            end
            2'd1: begin
                w_sel_val                          = r_edit_data[Field1Lsb +: FieldW];
                w_new_data[Field1Lsb +: FieldW]    = w_step_val;
            end
            default: begin
                w_sel_val                          = r_edit_data[Field2Lsb +: FieldW];
                w_new_data[Field2Lsb +: FieldW]    = w_step_val;
            end
        endcase
    end

    edit_field_ctrl_bcd_step u_bcd_step (
        .i_val    (w_sel_val),
        .i_min    (w_min),
        .i_max    (w_max),
        .i_dir_up (w_up_step),
        .o_val    (w_step_val)
    );

    // Edit FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_edit_data <= '0;
            r_cursor    <= 2'd0;
            r_edit_mode <= ModeNone;
            r_editing   <= 1'b0;
            r_write_req <= 1'b0;
            r_err       <= 1'b0;
            r_ack_cnt   <= '0;
            r_btn_prev  <= '0;
        end else begin
            r_btn_prev <= w_btn;
            r_err      <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_mode != ModeNone) begin
                        r_edit_data <= i_cur_data;
                        r_cursor    <= 2'd2;
                        r_edit_mode <= w_mode;
                        r_editing   <= 1'b1;
                        r_state     <= StEdit;
                    end
                end
                StEdit: begin
                    if (w_mode != r_edit_mode) begin
                        // Switch change abandons the edit without writing
                        r_editing <= 1'b0;
                        r_state   <= StIdle;
                    end else if (w_press[4]) begin
                        r_editing   <= 1'b0;
                        r_write_req <= 1'b1;
                        r_ack_cnt   <= '0;
                        r_state     <= StCommit;
                    end else if (w_up_step || w_down_step) begin
                        r_edit_data <= w_new_data;
                    end else if (w_press[1]) begin
                        r_cursor <= (r_cursor == 2'd2) ? 2'd0 : r_cursor + 2'd1;
                    end else if (w_press[0]) begin
                        r_cursor <= (r_cursor == 2'd0) ? 2'd2 : r_cursor - 2'd1;
                    end
                end
                StCommit: begin
                    if (i_write_ack) begin
                        r_write_req <= 1'b0;
                        r_state     <= StIdle;
                    end else if (r_ack_cnt == AckLast) begin
                        r_err       <= 1'b1;
                        r_write_req <= 1'b0;
                        r_state     <= StIdle;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_edit_data = r_edit_data;
    assign o_cursor    = r_cursor;
    assign o_edit_mode = r_edit_mode;
    assign o_editing   = r_editing;
    assign o_write_req = r_write_req;
    assign o_err       = r_err;

endmodule

// File: tb/tb_edit_field_ctrl.sv
// Directed bench for edit_field_ctrl: a vector table for single-cycle edits,
// followed by hand-written commit-timeout and mid-commit reset sequences.
module tb_edit_field_ctrl;

    localparam int unsigned TbAck = 255;

    logic        clk;
    logic        rst_n;
    logic        up, down, left, rigth, ok;
    logic        f0, f1, f2;
    logic [23:0] cur_data;
    logic        write_ack;
    logic [23:0] edit_data;
    logic [1:0]  cursor;
    logic [1:0]  edit_mode;
    logic        editing;
    logic        write_req;
    logic        err;

    int n_cmp;
    int n_bad;

    edit_field_ctrl #(
        .ACK_TIMEOUT   (TbAck),
        .HOLD_CYCLES   (50000000),
        .REPEAT_CYCLES (10000000)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_up        (up),
        .i_down      (down),
        .i_left      (left),
        .i_rigth     (rigth),
        .i_ok        (ok),
        .i_f0        (f0),
        .i_f1        (f1),
        .i_f2        (f2),
        .i_cur_data  (cur_data),
        .i_write_ack (write_ack),
        .o_edit_data (edit_data),
        .o_cursor    (cursor),
        .o_edit_mode (edit_mode),
        .o_editing   (editing),
        .o_write_req (write_req),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  btn;    // {ok, up, down, left, rigth}
        logic [2:0]  f;      // {f2, f1, f0}
        logic [23:0] cur;
        logic        ack;
        logic [23:0] e_data;
        logic [1:0]  e_cur;
        logic [1:0]  e_mode;
        logic        e_edit;
        logic        e_req;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] btn, input logic [2:0] f, input logic [23:0] cur,
                       input logic ack, input logic [23:0] e_data, input logic [1:0] e_cur,
                       input logic [1:0] e_mode, input logic e_edit, input logic e_req);
        vec_t v;
        v.btn = btn; v.f = f; v.cur = cur; v.ack = ack;
        v.e_data = e_data; v.e_cur = e_cur; v.e_mode = e_mode;
        v.e_edit = e_edit; v.e_req = e_req;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        {ok, up, down, left, rigth} = 5'b0;
        {f2, f1, f0} = 3'b0;
        cur_data  = 24'h235959;
        write_ack = 1'b0;

        // Hour mode: wraps and single-step on held Up
        add(5'b00000, 3'b001, 24'h235959, 0, 24'h235959, 2, 1, 1, 0);
        add(5'b01000, 3'b001, 24'h235959, 0, 24'h005959, 2, 1, 1, 0);
        add(5'b00000, 3'b001, 24'h235959, 0, 24'h005959, 2, 1, 1, 0);
        add(5'b00100, 3'b001, 24'h235959, 0, 24'h235959, 2, 1, 1, 0);
        add(5'b00000, 3'b001, 24'h235959, 0, 24'h235959, 2, 1, 1, 0);
        add(5'b01000, 3'b001, 24'h235959, 0, 24'h005959, 2, 1, 1, 0);
        add(5'b01000, 3'b001, 24'h235959, 0, 24'h005959, 2, 1, 1, 0);
        add(5'b00000, 3'b001, 24'h235959, 0, 24'h005959, 2, 1, 1, 0);
        add(5'b00110, 3'b001, 24'h235959, 0, 24'h235959, 2, 1, 1, 0);
        add(5'b00000, 3'b001, 24'h235959, 0, 24'h235959, 2, 1, 1, 0);
        add(5'b00010, 3'b001, 24'h235959, 0, 24'h235959, 0, 1, 1, 0);
        add(5'b00000, 3'b001, 24'h235959, 0, 24'h235959, 0, 1, 1, 0);
        add(5'b01000, 3'b001, 24'h235959, 0, 24'h235900, 0, 1, 1, 0);
        add(5'b00000, 3'b001, 24'h235959, 0, 24'h235900, 0, 1, 1, 0);
        add(5'b00001, 3'b001, 24'h235959, 0, 24'h235900, 2, 1, 1, 0);
        add(5'b00000, 3'b001, 24'h235959, 0, 24'h235900, 2, 1, 1, 0);
        add(5'b00001, 3'b001, 24'h235959, 0, 24'h235900, 1, 1, 1, 0);
        add(5'b00000, 3'b001, 24'h235959, 0, 24'h235900, 1, 1, 1, 0);
        add(5'b00100, 3'b001, 24'h235959, 0, 24'h235800, 1, 1, 1, 0);
        // F1 added while F0 stays high: no effect; then F0 drops: abort, reload as date
        add(5'b00000, 3'b011, 24'h311299, 0, 24'h235800, 1, 1, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h235800, 1, 1, 0, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h311299, 2, 2, 1, 0);
        // Date mode
        add(5'b00001, 3'b010, 24'h311299, 0, 24'h311299, 1, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h311299, 1, 2, 1, 0);
        add(5'b01000, 3'b010, 24'h311299, 0, 24'h310199, 1, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h310199, 1, 2, 1, 0);
        add(5'b00010, 3'b010, 24'h311299, 0, 24'h310199, 2, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h310199, 2, 2, 1, 0);
        add(5'b01000, 3'b010, 24'h311299, 0, 24'h010199, 2, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h010199, 2, 2, 1, 0);
        add(5'b01010, 3'b010, 24'h311299, 0, 24'h020199, 2, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h020199, 2, 2, 1, 0);
        add(5'b00100, 3'b010, 24'h311299, 0, 24'h010199, 2, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h010199, 2, 2, 1, 0);
        add(5'b00100, 3'b010, 24'h311299, 0, 24'h310199, 2, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h310199, 2, 2, 1, 0);
        add(5'b00001, 3'b010, 24'h311299, 0, 24'h310199, 1, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h310199, 1, 2, 1, 0);
        add(5'b00001, 3'b010, 24'h311299, 0, 24'h310199, 0, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h310199, 0, 2, 1, 0);
        add(5'b01000, 3'b010, 24'h311299, 0, 24'h310100, 0, 2, 1, 0);
        add(5'b00000, 3'b010, 24'h311299, 0, 24'h310100, 0, 2, 1, 0);
        add(5'b00100, 3'b010, 24'h311299, 0, 24'h310199, 0, 2, 1, 0);
        // Timer mode with an illegal hours byte; stray ack in EDIT is ignored
        add(5'b00000, 3'b100, 24'h7a0530, 0, 24'h310199, 0, 2, 0, 0);
        add(5'b00000, 3'b100, 24'h7a0530, 0, 24'h7a0530, 2, 3, 1, 0);
        add(5'b01000, 3'b100, 24'h7a0530, 0, 24'h000530, 2, 3, 1, 0);
        add(5'b00000, 3'b100, 24'h7a0530, 1, 24'h000530, 2, 3, 1, 0);
        add(5'b00100, 3'b100, 24'h7a0530, 0, 24'h230530, 2, 3, 1, 0);
        add(5'b00000, 3'b100, 24'h7a0530, 0, 24'h230530, 2, 3, 1, 0);
        // Ok beats Up; presses and mode change ignored in COMMIT; ack then reload
        add(5'b11000, 3'b100, 24'h7a0530, 0, 24'h230530, 2, 3, 0, 1);
        add(5'b00100, 3'b100, 24'h7a0530, 0, 24'h230530, 2, 3, 0, 1);
        add(5'b00000, 3'b001, 24'h7a0530, 0, 24'h230530, 2, 3, 0, 1);
        add(5'b00000, 3'b001, 24'h7a0530, 0, 24'h230530, 2, 3, 0, 1);
        add(5'b00000, 3'b001, 24'h7a0530, 1, 24'h230530, 2, 3, 0, 0);
        add(5'b00000, 3'b001, 24'h120000, 0, 24'h120000, 2, 1, 1, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset data", 32'(edit_data), 32'h0);
        chk("reset cursor", 32'(cursor), 32'h0);
        chk("reset mode", 32'(edit_mode), 32'h0);
        chk("reset editing", 32'(editing), 32'h0);
        chk("reset req", 32'(write_req), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            {ok, up, down, left, rigth} = vecs[i].btn;
            {f2, f1, f0} = vecs[i].f;
            cur_data  = vecs[i].cur;
            write_ack = vecs[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d data", i), 32'(edit_data), 32'(vecs[i].e_data));
            chk($sformatf("v%0d cursor", i), 32'(cursor), 32'(vecs[i].e_cur));
            chk($sformatf("v%0d mode", i), 32'(edit_mode), 32'(vecs[i].e_mode));
            chk($sformatf("v%0d editing", i), 32'(editing), 32'(vecs[i].e_edit));
            chk($sformatf("v%0d req", i), 32'(write_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d err", i), 32'(err), 32'h0);
        end

        // Commit with no ack: Err after exactly ACK_TIMEOUT cycles of Write_Req
        begin
            int  n;
            bit  req_dropped;
            @(negedge clk);
            write_ack = 1'b0;
            ok = 1'b1;
            @(posedge clk);
            #1;
            chk("timeout req rise", 32'(write_req), 32'h1);
            @(negedge clk);
            ok = 1'b0;
            n = 0;
            req_dropped = 1'b0;
            for (int k = 1; k <= 400; k++) begin
                @(posedge clk);
                #1;
                n = k;
                if (err) break;
                if (!write_req) req_dropped = 1'b1;
            end
            chk("timeout cycles", 32'(n), 32'(TbAck));
            chk("timeout err", 32'(err), 32'h1);
            chk("timeout req low", 32'(write_req), 32'h0);
            chk("timeout req held", 32'(req_dropped), 32'h0);
            @(posedge clk);
            #1;
            chk("timeout err pulse", 32'(err), 32'h0);
            chk("timeout reload", 32'(editing), 32'h1);
            chk("timeout data", 32'(edit_data), 32'h120000);
        end

        // Asynchronous reset in the middle of COMMIT
        @(negedge clk);
        ok = 1'b1;
        @(negedge clk);
        ok = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("midcommit req before", 32'(write_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async data", 32'(edit_data), 32'h0);
        chk("async cursor", 32'(cursor), 32'h0);
        chk("async mode", 32'(edit_mode), 32'h0);
        chk("async editing", 32'(editing), 32'h0);
        chk("async req", 32'(write_req), 32'h0);
        chk("async err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset reload", 32'(editing), 32'h1);
        chk("post reset mode", 32'(edit_mode), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
